// File: rtl/regfile_scan_ctrl.sv
// Serial debug/scan access controller for the general register file.
// Framed serial read/write commands; shares write port 1 with the core, core has priority.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module regfile_scan_ctrl #(
    parameter  int SIZE   = 16,
    parameter  int WIDTH  = `WORD_LENGTH,
    localparam int ADDR_W = $clog2(SIZE),
    localparam int CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sEnable,
    input  logic              sIn,
    output logic              sOut,
    output logic              busy,
    output logic              done,
    input  logic              coreWe,
    input  logic [ADDR_W-1:0] coreWAddr,
    input  logic [WIDTH-1:0]  coreWData,
    output logic              rfWe,
    output logic [ADDR_W-1:0] rfWAddr,
    output logic [WIDTH-1:0]  rfWData,
    output logic [ADDR_W-1:0] rfRAddr,
    input  logic [WIDTH-1:0]  rfRData
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD_ADDR = 3'd1;
    localparam logic [2:0] S_DATA_IN  = 3'd2;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_DATA_OUT = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_END      = 3'd6;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

    logic [2:0]        state_q, state_d;
    logic              cmd_q,   cmd_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              done_q,  done_d;
    logic              grant;

    // Debug write owns port 1 only while waiting in WRITE with the core idle; r0 is never written.
    assign grant = (state_q == S_WRITE) && !coreWe && (addr_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sEnable) begin
                    cmd_d   = sIn;
                    cnt_d   = '0;
                    state_d = S_CMD_ADDR;
                end
            end
            S_CMD_ADDR: begin
                if (!sEnable) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = ADDR_W'({addr_q, sIn});
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = cmd_q ? S_DATA_IN : S_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA_IN: begin
                if (!sEnable) begin
                    state_d = S_IDLE;
                end else begin
                    data_d = WIDTH'({data_q, sIn});
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (!sEnable) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = rfRData;
                    cnt_d   = '0;
                    state_d = S_DATA_OUT;
                end
            end
            S_DATA_OUT: begin
                if (!sEnable) begin
                    state_d = S_IDLE;
                end else begin
                    data_d = {data_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_END;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // Committed: sEnable is ignored, only the core can stall completion.
                if (!coreWe || (addr_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!sEnable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign rfWe    = grant ? 1'b1   : coreWe;
    assign rfWAddr = grant ? addr_q : coreWAddr;
    assign rfWData = grant ? data_q : coreWData;
    assign rfRAddr = addr_q;
    assign sOut    = (state_q == S_DATA_OUT) && data_q[WIDTH-1];
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

endmodule

// File: doc/regfile_scan_ctrl.md
Name: regfile_scan_ctrl

Overview:
Serial debug/scan access controller for the general register file (RegisterFile_2R_1W / _3R_2W family).
- Receives framed serial read/write commands, one bit per clk, and drives a dedicated register-file read port for reads.
- Shares the register file's write port 1 with the core writeback path; core has strict priority.
- Sits between the JTAG/debug front end (bits already synchronised to clk) and the register file.

Parameters:
SIZE, 16, number of registers; ADDR_W = $clog2(SIZE)
WIDTH, `WORD_LENGTH, register width in bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
sEnable  in  1  frame enable; high for whole transaction, bits sampled on clk when high
sIn  in  1  serial data in, MSB first
sOut  out  1  serial data out (read data), MSB first
busy  out  1  transaction in progress (state != IDLE)
done  out  1  one-cycle pulse on transaction completion
coreWe  in  1  core write enable
coreWAddr  in  ADDR_W  core write address
coreWData  in  WIDTH  core write data
rfWe  out  1  to register file writeEnable1
rfWAddr  out  ADDR_W  to register file writeAddr1
rfWData  out  WIDTH  to register file writeData1
rfRAddr  out  ADDR_W  to register file debug read port address
rfRData  in  WIDTH  register file debug read port data (async)

Behaviour:
- Reset (async, rst low): state IDLE; sOut=0, busy=0, done=0; address/data shift registers and bit counter cleared. rfW* outputs are the core passthrough, so rfWe=coreWe even in reset. Reset mid-transaction discards it with no write issued.
- Frame format: 1 cmd bit (1=write, 0=read), then ADDR_W address bits, then for writes WIDTH data bits. All fields are MSB first and one bit per clk with sEnable high.
- States and transitions:
  - IDLE -> CMD_ADDR on the first clk with sEnable=1. That bit is latched as cmd.
  - CMD_ADDR shifts ADDR_W address bits, counted by a bit counter.
  - Read: CMD_ADDR -> CAPTURE. Write: CMD_ADDR -> DATA_IN.
  - DATA_IN shifts WIDTH bits -> WRITE.
  - CAPTURE lasts one cycle: rfRAddr = address register; rfRData loaded into the shift register; sIn ignored -> DATA_OUT.
  - DATA_OUT: sOut = shift register MSB; shift left on each clk with sEnable=1; after WIDTH shifts -> END with done=1 for one cycle.
  - WRITE: if coreWe=0, rfWe=1, rfWAddr=address, rfWData=data for exactly one cycle, then done=1 next cycle -> END. If coreWe=1, core passes through and the controller waits in WRITE (no timeout).
  - END -> IDLE when sEnable=0.
- Write to address 0: WRITE completes in one cycle with rfWe=0 (no write issued), done still pulses.
- Abort: sEnable=0 in CMD_ADDR, DATA_IN, CAPTURE or DATA_OUT -> IDLE next clk. No write, no done.
- WRITE is committed and ignores sEnable.
- sOut=0 outside DATA_OUT.
- Bit counter width: $clog2(WIDTH)+1. It is reset at each field boundary.
- Passthrough rule: outside the WRITE grant cycle, rfWe/rfWAddr/rfWData equal coreWe/coreWAddr/coreWData combinationally.
- Latency:
  - Write: last data bit edge -> rfWe high in the next cycle if the core is idle.
  - Read: last address bit -> 1 CAPTURE cycle -> first data bit valid on sOut.

Test Plan:
1. SIZE=16, WIDTH=32, core idle; frame write r5=0xDEADBEEF (1, 0101, 32 data bits) -> rfWe=1 for exactly one cycle with rfWAddr=5, rfWData=0xDEADBEEF; done pulses the next cycle; busy drops after sEnable=0.
2. Read r5 after test 1 -> CAPTURE cycle with rfRAddr=5; sOut shifts 1101_1110...1111 (0xDEADBEEF MSB first) over 32 clks; done=1 once.
3. Write r3=0x12345678 with coreWe=1, coreWAddr=7 held 3 cycles at WRITE entry -> rfW* follow the core for 3 cycles; debug write issued on the 4th cycle; both values read back correctly.
4. Write r0=0xFFFFFFFF -> rfWe never asserted by the controller; done pulses; a subsequent read of r0 returns 0x00000000.
5. Drop sEnable after 10 of 32 data bits of a write to r2 -> state returns to IDLE, no rfWe, no done; r2 unchanged. A new frame then works normally.
6. Assert rst low mid DATA_OUT -> sOut=0, busy=0 immediately (async); no done. A frame after rst release works normally.
